// File: rtl/upio_in_filter.sv
// Per-line pad synchronizer and debounce filter feeding upio_in.
// Each line accepts a new level after it has been seen steadily for max(P,1) cycles.
module upio_in_filter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     pad_i,
  input  logic                 cfg_en_i,
  input  logic [CNT_WIDTH-1:0] cfg_period_i,
  output logic [WIDTH-1:0]     upio_in_o,
  output logic [WIDTH-1:0]     rise_o,
  output logic [WIDTH-1:0]     fall_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync;
  logic [WIDTH-1:0]                  stable_q, stable_d;
  logic [WIDTH-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic [CNT_WIDTH-1:0]              thresh;

  // Synchronizer chain keeps shifting regardless of cfg_en_i.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
  assign sync   = sync_q[SYNC_STAGES-1];

  // Peff-1 with P=0 treated as P=1.
  assign thresh = (cfg_period_i == '0) ? '0 : cfg_period_i - CNT_WIDTH'(1);

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = '0;
    fall_d   = '0;
    if (cfg_en_i) begin
      for (int n = 0; n < int'(WIDTH); n++) begin
        if (sync[n] == stable_q[n]) begin
          cnt_d[n] = '0;
        end else if (cnt_q[n] >= thresh) begin
          stable_d[n] = sync[n];
          cnt_d[n]    = '0;
          rise_d[n]   = sync[n];
          fall_d[n]   = ~sync[n];
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign upio_in_o = stable_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;

endmodule

// File: tb/tb_upio_in_filter.sv
// Randomized + directed bench for upio_in_filter against a run-length debounce model.
module tb_upio_in_filter;

  localparam int unsigned W  = 8;
  localparam int unsigned S  = 2;
  localparam int unsigned CW = 16;

  logic          clk;
  logic          rst;
  logic [W-1:0]  pad;
  logic          en;
  logic [CW-1:0] per;
  logic [W-1:0]  upio, rise, fall;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 0;

  upio_in_filter #(.WIDTH(W), .SYNC_STAGES(S), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .pad_i(pad), .cfg_en_i(en), .cfg_period_i(per),
    .upio_in_o(upio), .rise_o(rise), .fall_o(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pad delayed S cycles, then a line flips once it has differed for Peff enabled cycles in a row.
  logic [W-1:0] m_hist [S];
  logic [W-1:0] m_stable, m_rise, m_fall;
  int           m_run [W];

  always @(posedge clk) begin
    logic [W-1:0] sv;
    int peff;
    if (rst) begin
      for (int i = 0; i < int'(S); i++) m_hist[i] = '0;
      for (int n = 0; n < int'(W); n++) m_run[n] = 0;
      m_stable = '0; m_rise = '0; m_fall = '0;
      chk_on = 1;
    end else begin
      sv = m_hist[S-1];
      peff = (per == 0) ? 1 : int'(per);
      m_rise = '0; m_fall = '0;
      if (en) begin
        for (int n = 0; n < int'(W); n++) begin
          if (sv[n] != m_stable[n]) begin
            m_run[n]++;
            if (m_run[n] >= peff) begin
              m_stable[n] = sv[n];
              m_run[n] = 0;
              if (sv[n]) m_rise[n] = 1'b1; else m_fall[n] = 1'b1;
            end
          end else begin
            m_run[n] = 0;
          end
        end
      end
      for (int i = int'(S) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pad;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_upio", upio, m_stable);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
      check("rise_fall_excl", rise & fall, '0);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    pad = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pad = '0; en = 1'b1; per = CW'(4);
    step(); step();
    check("reset_upio", upio, 8'h00);
    check("reset_rise", rise, 8'h00);
    check("reset_fall", fall, 8'h00);
    rst = 1'b0;

    // Single line rise, P=4: change at edge 5.
    pad = 8'h01;
    for (int k = 0; k < 8; k++) begin
      step();
      check("p4_upio", upio, (k >= 5) ? 8'h01 : 8'h00);
      check("p4_rise", rise, (k == 5) ? 8'h01 : 8'h00);
    end

    // Three-cycle glitch on line 3 is rejected.
    pad = 8'h09;
    repeat (3) step();
    pad = 8'h01;
    for (int k = 0; k < 10; k++) begin
      step();
      check("glitch_upio", upio, 8'h01);
      check("glitch_pulse", rise | fall, 8'h00);
    end

    // P=0 and P=1 behave identically: change at edge 2.
    for (int p = 0; p < 2; p++) begin
      do_reset();
      per = CW'(p);
      pad = 8'h80;
      for (int k = 0; k < 4; k++) begin
        step();
        check("p01_upio", upio, (k >= 2) ? 8'h80 : 8'h00);
        check("p01_rise", rise, (k == 2) ? 8'h80 : 8'h00);
      end
    end

    // Lowering the period below the running count accepts on the next mismatch.
    do_reset();
    per = CW'(100);
    pad = 8'h02;
    repeat (52) step();
    check("lower_before", upio | rise, 8'h00);
    per = CW'(10);
    step();
    check("lower_rise", rise, 8'h02);
    check("lower_upio", upio, 8'h02);

    // Disabled filter holds; re-enable accepts all lines together.
    do_reset();
    per = CW'(4);
    en = 1'b0;
    pad = 8'hFF;
    repeat (200) step();
    check("dis_upio", upio, 8'h00);
    en = 1'b1;
    repeat (3) step();
    check("reen_early", rise | upio, 8'h00);
    step();
    check("reen_rise", rise, 8'hFF);
    check("reen_upio", upio, 8'hFF);

    // Reset mid-count discards the pending transition.
    do_reset();
    per = CW'(4);
    pad = 8'h0F;
    repeat (4) step();
    rst = 1'b1;
    step();
    check("midrst_upio", upio, 8'h00);
    check("midrst_rise", rise, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("postrst_rise", rise, (k == 5) ? 8'h0F : 8'h00);
    end

    // Random traffic checked by the model every cycle.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int n = 0; n < int'(W); n++)
        if ($urandom_range(0, 7) == 0) pad[n] = ~pad[n];
      if ($urandom_range(0, 49) == 0) per = CW'($urandom_range(0, 5));
      en  = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
